pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three cases: load-use hazards, branches resolved in MEM, and a variable-latency data memory (ready handshake) with timeout.
- Holds a small FSM plus saturating performance counters.

Parameters:
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before entering ERROR (range 1..255).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- ifid_rs1  input  5  rs1 of instruction in IF/ID
- ifid_rs2  input  5  rs2 of instruction in IF/ID
- idex_MemRead  input  1  load in ID/EX
- idex_rd  input  5  destination of instruction in ID/EX
- exmem_MemRead  input  1  load in EX/MEM (issuing to dmem)
- exmem_MemWrite  input  1  store in EX/MEM
- dmem_ready  input  1  data memory completes access this cycle
- branch_taken  input  1  taken branch/jump resolved in EX/MEM
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID clear to NOP
- idex_write  output  1  ID/EX load enable
- idex_flush  output  1  ID/EX control bits zeroed (bubble)
- exmem_write  output  1  EX/MEM load enable
- exmem_flush  output  1  EX/MEM control bits zeroed
- memwb_bubble  output  1  force RegWrite/MemtoReg inputs of MEM/WB to 0
- mem_err  output  1  sticky dmem timeout flag
- stall_cycles  output  CNT_W  count of cycles with pc_write=0
- flush_count  output  CNT_W  count of branch flush events

Behaviour:
- Reset (synchronous, active-high): state=RUN, wait counter=0, mem_err=0, both counters=0. While reset is high, all write enables=1 and all flush/bubble outputs=0. Reset mid-MEM_WAIT or in ERROR returns to RUN next cycle.
- State and counters are registered. Control outputs are combinational from state and current inputs, taking effect at the same clock edge.
- Definitions:
  - memacc = exmem_MemRead | exmem_MemWrite
  - load_use = idex_MemRead & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2)
- RUN, priority highest first:
  1. memacc & !dmem_ready: all *_write=0, memwb_bubble=1, no flushes; next=MEM_WAIT, wait counter=1.
  2. branch_taken: all writes=1; ifid_flush=idex_flush=exmem_flush=1; flush_count++. Load-use is ignored the same cycle (the flushed instruction is discarded).
  3. load_use: pc_write=ifid_write=0, idex_flush=1, idex_write=1, exmem/memwb normal. This is a one-cycle bubble.
  4. Otherwise: all writes=1, no flushes, memwb_bubble=0.
- MEM_WAIT:
  - dmem_ready=1: treat as RUN this cycle (apply rules 2-4 against current inputs); next=RUN, wait counter cleared.
  - dmem_ready=0: freeze as rule 1.
    - If wait counter==MEM_TIMEOUT: next=ERROR, mem_err=1.
    - Else wait counter++.
- ERROR: all *_write=0, memwb_bubble=1, flushes=0. Stays in ERROR until reset; dmem_ready is ignored.
- stall_cycles increments every cycle pc_write=0 (reset cycles excluded). Both counters saturate at all-ones with no wrap.
- branch_taken & memacc simultaneously cannot occur (same stage, a branch does no memory access). The bench flags it as an assertion; the RTL applies rule 1.
- Wait counter is 8 bits.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2
  - REG_X0 = 5'd0
  - default MEM_TIMEOUT
- One natural sub-module: sat_counter (parameter W; inputs inc, clk, reset; output count). Instantiated twice for the performance counters.

Test Plan:
- Load-use: idex_MemRead=1, idex_rd=5, ifid_rs1=5, dmem_ready=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1; next cycle all writes=1.
- x0 exclusion: idex_MemRead=1, idex_rd=0, ifid_rs2=0 -> no stall, all writes=1.
- Mem wait: exmem_MemRead=1, dmem_ready low 3 cycles then high -> 3 cycles of all writes=0 with memwb_bubble=1, then RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, exmem_MemWrite=1, dmem_ready held 0 -> ERROR after 5th wait cycle, mem_err=1 sticky; dmem_ready=1 has no effect; reset -> RUN, mem_err=0.
- Branch vs load-use: branch_taken=1 with load_use true -> ifid/idex/exmem_flush=1, pc_write=1, flush_count=1, no stall.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t               : controller states (RUN / MEM_WAIT / ERROR)
//   REG_X0                : architectural zero register, never a hazard source
//   MEM_TIMEOUT_DEFAULT   : default limit on consecutive dmem wait cycles
//   WAIT_W                : width of the dmem wait counter
//   load_use_hazard()     : load-use detection between ID/EX and IF/ID
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0              = 5'd0;
  localparam int         MEM_TIMEOUT_DEFAULT = 15;
  localparam int         WAIT_W              = 8;

  // A load in ID/EX whose destination feeds the instruction in IF/ID.
  // Writes to x0 are discarded by the register file, so they never stall.
  function automatic logic load_use_hazard(input logic       mem_read,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : system clock, rising edge
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Inputs : clk, reset (sync, active-high); IF/ID source regs; ID/EX load
//          info; EX/MEM memory access flags; dmem_ready; branch_taken.
// Outputs: write enables and flush/bubble controls for PC, IF/ID, ID/EX,
//          EX/MEM and MEM/WB (combinational from state + inputs); sticky
//          mem_err; saturating stall_cycles and flush_count counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_set;
  logic              freeze;
  logic              run_rules;
  logic              memacc;
  logic              load_use;

  assign memacc   = exmem_MemRead | exmem_MemWrite;
  assign load_use = load_use_hazard(idex_MemRead, idex_rd, ifid_rs1, ifid_rs2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= mem_err | err_set;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_set      = 1'b0;
    freeze       = 1'b0;
    run_rules    = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;

    // While reset is asserted the defaults (all writes on, no flushes) stand.
    if (!reset) begin
      unique case (state)
        RUN: begin
          // A pending memory access outranks a simultaneous branch.
          if (memacc && !dmem_ready) begin
            freeze    = 1'b1;
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else begin
            run_rules = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            run_rules = 1'b1;
            state_nxt = RUN;
            wait_nxt  = '0;
          end else begin
            freeze = 1'b1;
            if (wait_cnt == TIMEOUT) begin
              state_nxt = ERROR;
              err_set   = 1'b1;
            end else begin
              wait_nxt = wait_cnt + 1'b1;
            end
          end
        end
        ERROR: begin
          freeze = 1'b1;
        end
        default: begin
          freeze    = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      endcase
    end

    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (run_rules) begin
      if (branch_taken) begin
        // The instruction that would have caused a load-use stall is
        // squashed by this flush, so no stall is needed.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule
